fptd_iteration_ctrl: RTL

//  Sequences a pipelined FPTD section array through decoding iterations with razor error recovery.
//  - Each iteration = EVEN half (Gamma/Ext banks) then ODD half (Alpha/Beta/Epsilon banks).
//  - ORs per-section error flags and replays a failed half after a recovery window.
//  - Aborts if replays exceed a bound.
//  - Sits between the frame loader and the section array; drives bank clock-enables.

---
 rtl/fptd_ctrl_pkg.sv | 28 ++
 rtl/razor_error_collector.sv | 37 +++
 rtl/fptd_iteration_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fptd_ctrl_pkg.sv
// Shared types and helpers for the FPTD iteration controller.
package fptd_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EXEC   = 3'd2,
        CHECK  = 3'd3,
        REPLAY = 3'd4,
        FINISH = 3'd5
    } ctrl_state_t;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    localparam int unsigned SAT_MAX_W = 64;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input int unsigned        w);
        logic [SAT_MAX_W-1:0] ones;
        ones = (w >= SAT_MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == ones) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/razor_error_collector.sv
// OR-reduces per-section razor flags during CHECK and keeps a saturating
// per-frame event count.
module razor_error_collector
    import fptd_ctrl_pkg::*;
#(
    parameter int P     = 64,
    parameter int ERR_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_check,
    input  logic             i_clear,
    input  logic [P-1:0]     i_error_section,
    output logic             o_err,
    output logic [ERR_W-1:0] o_error_count
);

    logic             w_err;
    logic [ERR_W-1:0] r_count;

    // The gate keeps glitches or X on the flags from leaking out of CHECK.
    assign w_err = i_check & (|i_error_section);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_err) begin
            r_count <= ERR_W'(sat_inc(64'(r_count), ERR_W));
        end
    end

    assign o_err         = w_err;
    assign o_error_count = r_count;

endmodule

// File: rtl/fptd_iteration_ctrl.sv
// Iteration sequencer for a pipelined FPTD section array: alternates even and
// odd half-iterations, replays a half on a razor error and aborts on overflow.
module fptd_iteration_ctrl
    import fptd_ctrl_pkg::*;
#(
    parameter int P          = 64,
    parameter int MAX_ITER   = 16,
    parameter int REPLAY_CYC = 2,
    parameter int MAX_REPLAY = 3,
    parameter int ERR_W      = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic                            i_stop,
    input  logic [P-1:0]                    i_error_section,
    output logic                            o_load_frame,
    output logic                            o_clear_state,
    output logic                            o_en_even,
    output logic                            o_en_odd,
    output logic                            o_replay,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_fail,
    output logic [$clog2(MAX_ITER+1)-1:0]   o_iter_count,
    output logic [ERR_W-1:0]                o_error_count
);

    localparam int IW  = $clog2(MAX_ITER + 1);
    localparam int RCW = $clog2(MAX_REPLAY + 1);
    localparam int TW  = $clog2(REPLAY_CYC + 1);

    ctrl_state_t   r_state, w_state_nx;
    phase_t        r_ph, w_ph_nx;
    logic [RCW-1:0] r_rc, w_rc_nx;
    logic [TW-1:0]  r_rtmr, w_rtmr_nx;
    logic [IW-1:0]  r_iter, w_iter_nx, w_iter_inc;
    logic           r_fail, w_fail_nx;
    logic           w_clr;
    logic           w_err;

    logic r_load, r_en_even, r_en_odd, r_replay, r_busy, r_done;

    razor_error_collector #(
        .P     (P),
        .ERR_W (ERR_W)
    ) u_collector (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_check         (r_state == CHECK),
        .i_clear         (w_clr),
        .i_error_section (i_error_section),
        .o_err           (w_err),
        .o_error_count   (o_error_count)
    );

    assign w_iter_inc = r_iter + 1'b1;

    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_rc_nx    = r_rc;
        w_rtmr_nx  = r_rtmr;
        w_iter_nx  = r_iter;
        w_fail_nx  = r_fail;
        w_clr      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nx = LOAD;
                    w_iter_nx  = '0;
                    w_fail_nx  = 1'b0;
                    w_clr      = 1'b1;
                end
            end
            LOAD: begin
                w_state_nx = EXEC;
                w_ph_nx    = EVEN;
                w_rc_nx    = '0;
            end
            EXEC: w_state_nx = CHECK;
            CHECK: begin
                if (w_err) begin
                    if (r_rc < RCW'(MAX_REPLAY)) begin
                        w_state_nx = REPLAY;
                        w_rc_nx    = r_rc + 1'b1;
                        w_rtmr_nx  = '0;
                    end else begin
                        w_state_nx = FINISH;
                        w_fail_nx  = 1'b1;
                    end
                end else if (r_ph == EVEN) begin
                    w_state_nx = EXEC;
                    w_ph_nx    = ODD;
                    w_rc_nx    = '0;
                end else begin
                    w_iter_nx = w_iter_inc;
                    w_rc_nx   = '0;
                    w_ph_nx   = EVEN;
                    // Stop is only looked at here, at a completed iteration.
                    if ((w_iter_inc == IW'(MAX_ITER)) || i_stop) begin
                        w_state_nx = FINISH;
                    end else begin
                        w_state_nx = EXEC;
                    end
                end
            end
            REPLAY: begin
                if (r_rtmr == TW'(REPLAY_CYC - 1)) begin
                    w_state_nx = EXEC;
                end else begin
                    w_rtmr_nx = r_rtmr + 1'b1;
                end
            end
            FINISH:  w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ph      <= EVEN;
            r_rc      <= '0;
            r_rtmr    <= '0;
            r_iter    <= '0;
            r_fail    <= 1'b0;
            r_load    <= 1'b0;
            r_en_even <= 1'b0;
            r_en_odd  <= 1'b0;
            r_replay  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ph      <= w_ph_nx;
            r_rc      <= w_rc_nx;
            r_rtmr    <= w_rtmr_nx;
            r_iter    <= w_iter_nx;
            r_fail    <= w_fail_nx;
            r_load    <= (w_state_nx == LOAD);
            r_en_even <= (w_state_nx == EXEC) && (w_ph_nx == EVEN);
            r_en_odd  <= (w_state_nx == EXEC) && (w_ph_nx == ODD);
            r_replay  <= (w_state_nx == REPLAY);
            r_busy    <= (w_state_nx == LOAD) || (w_state_nx == EXEC) ||
                         (w_state_nx == CHECK) || (w_state_nx == REPLAY);
            r_done    <= (w_state_nx == FINISH);
        end
    end

    assign o_load_frame  = r_load;
    assign o_clear_state = r_load;
    assign o_en_even     = r_en_even;
    assign o_en_odd      = r_en_odd;
    assign o_replay      = r_replay;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_fail        = r_fail;
    assign o_iter_count  = r_iter;

endmodule
